config_chain_loader: RTL and testbench

//  Synthesizable successor to the bench-side bitstream shifter. Streams a bitstream, supplied as parallel

---
 rtl/config_chain_loader_pkg.sv | 22 ++
 rtl/config_chain_loader_if.sv | 13 +
 rtl/config_chain_loader_phase_timer.sv | 33 +++
 rtl/config_chain_loader.sv | 150 +++++++++++++++
 tb/tb_config_chain_loader.sv | 390 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/config_chain_loader_pkg.sv
// Shared types and constants for the configuration chain loader.
// Holds the FSM state encoding, the error counter width and a parameter legality check.
package config_chain_loader_pkg;

    localparam int ERR_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_PASS_END = 3'd4,
        ST_FINISH   = 3'd5
    } state_t;

    // Word must split evenly across chains, and a pass must be a whole number of words.
    function automatic bit params_legal(input int cw, input int nc, input int ww, input int div);
        return (cw >= 2) && (nc >= 1) && (div >= 1) && (ww >= nc) &&
               (ww % nc == 0) && ((cw * nc) % ww == 0);
    endfunction

endpackage

// File: rtl/config_chain_loader_if.sv
// Bitstream word port between the source (ROM/UART/bench) and the loader.
// A word transfers on a rising clk edge where word_valid and word_ready are both high;
// the source holds word_data stable while word_valid is high and may not retract it before the transfer.
interface config_chain_loader_if #(
    parameter int WORD_WIDTH = 32
);
    logic [WORD_WIDTH-1:0] word_data;
    logic                  word_valid;
    logic                  word_ready;

    modport master (output word_data, output word_valid, input word_ready);
    modport slave  (input word_data, input word_valid, output word_ready);
endinterface

// File: rtl/config_chain_loader_phase_timer.sv
// Down-counter that times one config_clk half-period of CLK_DIV clk cycles.
// phase_last_o marks the final cycle of the current LO or HI phase.
module config_phase_timer #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    output logic phase_last_o
);
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign phase_last_o = run_i && (cnt_q == '0);

    // Reloads whenever a phase ends or no phase is running, so each phase starts full.
    always_comb begin
        cnt_d = RELOAD;
        if (run_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/config_chain_loader.sv
// Streams a word-supplied bitstream into NUM_CHAINS config shift chains, optionally
// re-streaming it to check every bit the chains shift out.
module config_chain_loader
    import config_chain_loader_pkg::*;
#(
    parameter int CONFIG_WIDTH = 1024,
    parameter int NUM_CHAINS   = 1,
    parameter int WORD_WIDTH   = 32,
    parameter int CLK_DIV      = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic                    verify_i,
    config_chain_loader_if.slave    word_if,
    output logic [NUM_CHAINS-1:0]   config_in_o,
    output logic                    config_clk_o,
    output logic                    config_en_o,
    input  logic [NUM_CHAINS-1:0]   config_out_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    error_o,
    output logic [ERR_CNT_W-1:0]    err_count_o,
    output state_t                  dbg_state_o
);
    localparam int SLICES = WORD_WIDTH / NUM_CHAINS;
    localparam int PCW    = $clog2(CONFIG_WIDTH + 1);
    localparam int SCW    = $clog2(SLICES + 1);

    if (!params_legal(CONFIG_WIDTH, NUM_CHAINS, WORD_WIDTH, CLK_DIV)) begin : g_bad_params
        $error("config_chain_loader: illegal parameter combination");
    end

    state_t                 state_q, state_d;
    logic [WORD_WIDTH-1:0]  buf_q, buf_d;
    logic [PCW-1:0]         pulse_q, pulse_d;
    logic [SCW-1:0]         slice_q, slice_d;
    logic                   verify_q, verify_d;
    logic                   pass_q, pass_d;
    logic                   error_q, error_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic                   clk_q;
    logic                   in_phase, phase_last, mismatch;

    assign in_phase = (state_q == ST_SHIFT_LO) || (state_q == ST_SHIFT_HI);
    assign mismatch = (config_out_i != buf_q[NUM_CHAINS-1:0]);

    config_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk          (clk),
        .rst          (rst),
        .run_i        (in_phase),
        .phase_last_o (phase_last)
    );

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        pulse_d   = pulse_q;
        slice_d   = slice_q;
        verify_d  = verify_q;
        pass_d    = pass_q;
        error_d   = error_q;
        err_cnt_d = err_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    verify_d  = verify_i;
                    pass_d    = 1'b0;
                    pulse_d   = '0;
                    error_d   = 1'b0;
                    err_cnt_d = '0;
                    state_d   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (word_if.word_valid) begin
                    buf_d   = word_if.word_data;
                    slice_d = '0;
                    state_d = ST_SHIFT_LO;
                end
            end
            ST_SHIFT_LO: begin
                if (phase_last) begin
                    // One count per pulse regardless of how many chains disagree.
                    if (pass_q && mismatch) begin
                        error_d = 1'b1;
                        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                    end
                    state_d = ST_SHIFT_HI;
                end
            end
            ST_SHIFT_HI: begin
                if (phase_last) begin
                    buf_d   = buf_q >> NUM_CHAINS;
                    slice_d = slice_q + SCW'(1);
                    pulse_d = pulse_q + PCW'(1);
                    if (pulse_q == PCW'(CONFIG_WIDTH - 1))  state_d = ST_PASS_END;
                    else if (slice_q == SCW'(SLICES - 1))   state_d = ST_FETCH;
                    else                                    state_d = ST_SHIFT_LO;
                end
            end
            ST_PASS_END: begin
                pulse_d = '0;
                if (verify_q && !pass_q) begin
                    pass_d  = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            buf_q     <= '0;
            pulse_q   <= '0;
            slice_q   <= '0;
            verify_q  <= 1'b0;
            pass_q    <= 1'b0;
            error_q   <= 1'b0;
            err_cnt_q <= '0;
            clk_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            pulse_q   <= pulse_d;
            slice_q   <= slice_d;
            verify_q  <= verify_d;
            pass_q    <= pass_d;
            error_q   <= error_d;
            err_cnt_q <= err_cnt_d;
            clk_q     <= (state_d == ST_SHIFT_HI);
        end
    end

    // config_clk comes straight from a flop so the chains never see decode glitches.
    assign config_clk_o       = clk_q;
    assign config_in_o        = in_phase ? buf_q[NUM_CHAINS-1:0] : '0;
    assign config_en_o        = (state_q != ST_IDLE) && (state_q != ST_FINISH);
    assign busy_o             = config_en_o;
    assign done_o             = (state_q == ST_FINISH);
    assign word_if.word_ready = (state_q == ST_FETCH);
    assign error_o            = error_q;
    assign err_count_o        = err_cnt_q;
    assign dbg_state_o        = state_q;
endmodule

// File: tb/tb_config_chain_loader.sv
// Bench for config_chain_loader: three parameterisations, behavioural shift-chain models,
// a vector table for the 8-bit chain and randomized runs against a stream reference model.
module tb_config_chain_loader;
    import config_chain_loader_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- u1: CW=8 NC=1 WW=8 DIV=1 ----------------
    config_chain_loader_if #(.WORD_WIDTH(8)) w1 ();
    logic start1 = 1'b0, verify1 = 1'b0;
    logic [0:0] cin1, cout1;
    logic cclk1, cen1, busy1, done1, err1;
    logic [15:0] ecnt1;
    state_t st1;

    config_chain_loader #(.CONFIG_WIDTH(8), .NUM_CHAINS(1), .WORD_WIDTH(8), .CLK_DIV(1)) u1 (
        .clk(clk), .rst(rst), .start_i(start1), .verify_i(verify1), .word_if(w1.slave),
        .config_in_o(cin1), .config_clk_o(cclk1), .config_en_o(cen1), .config_out_i(cout1),
        .busy_o(busy1), .done_o(done1), .error_o(err1), .err_count_o(ecnt1), .dbg_state_o(st1));

    logic [7:0] chain1 = '0;
    logic [7:0] flip1 = '0;
    int nrise1 = 0;
    int ndone1 = 0;
    logic [0:0] rises1[$];
    assign cout1 = chain1[7];

    always @(posedge cclk1) begin : chain1_model
        logic [7:0] nxt;
        nxt = {chain1[6:0], cin1};
        nrise1++;
        rises1.push_back(cin1);
        // Corrupt the stored load-pass bit i (now at stage 7-i) once the load pass is complete.
        if (nrise1 == 8) for (int i = 0; i < 8; i++) nxt[7-i] = nxt[7-i] ^ flip1[i];
        chain1 <= nxt;
    end
    always @(negedge clk) if (done1) ndone1++;

    // ---------------- u4: CW=4 NC=4 WW=16 DIV=1 ----------------
    config_chain_loader_if #(.WORD_WIDTH(16)) w4 ();
    logic start4 = 1'b0, verify4 = 1'b0;
    logic [3:0] cin4, cout4;
    logic cclk4, cen4, busy4, done4, err4;
    logic [15:0] ecnt4;
    state_t st4;
    logic [3:0] rises4[$];
    int ndone4 = 0;
    assign cout4 = '0;

    config_chain_loader #(.CONFIG_WIDTH(4), .NUM_CHAINS(4), .WORD_WIDTH(16), .CLK_DIV(1)) u4 (
        .clk(clk), .rst(rst), .start_i(start4), .verify_i(verify4), .word_if(w4.slave),
        .config_in_o(cin4), .config_clk_o(cclk4), .config_en_o(cen4), .config_out_i(cout4),
        .busy_o(busy4), .done_o(done4), .error_o(err4), .err_count_o(ecnt4), .dbg_state_o(st4));

    always @(posedge cclk4) rises4.push_back(cin4);
    always @(negedge clk) if (done4) ndone4++;

    // ---------------- u5: CW=64 NC=1 WW=32 DIV=3 ----------------
    config_chain_loader_if #(.WORD_WIDTH(32)) w5 ();
    logic start5 = 1'b0, verify5 = 1'b0;
    logic [0:0] cin5, cout5;
    logic cclk5, cen5, busy5, done5, err5;
    logic [15:0] ecnt5;
    state_t st5;

    config_chain_loader #(.CONFIG_WIDTH(64), .NUM_CHAINS(1), .WORD_WIDTH(32), .CLK_DIV(3)) u5 (
        .clk(clk), .rst(rst), .start_i(start5), .verify_i(verify5), .word_if(w5.slave),
        .config_in_o(cin5), .config_clk_o(cclk5), .config_en_o(cen5), .config_out_i(cout5),
        .busy_o(busy5), .done_o(done5), .error_o(err5), .err_count_o(ecnt5), .dbg_state_o(st5));

    logic [63:0] chain5 = '0;
    logic [63:0] flip5 = '0;
    int nrise5 = 0;
    int ndone5 = 0;
    logic [0:0] rises5[$];
    logic [0:0] exp_q[$];
    assign cout5 = chain5[63];

    always @(posedge cclk5) begin : chain5_model
        logic [63:0] nxt;
        nxt = {chain5[62:0], cin5};
        nrise5++;
        rises5.push_back(cin5);
        if (nrise5 == 64) for (int i = 0; i < 64; i++) nxt[63-i] = nxt[63-i] ^ flip5[i];
        chain5 <= nxt;
    end
    always @(negedge clk) if (done5) ndone5++;

    // Phase timing: every HI is 3 cycles; a LO with no fetch inside it is 3 cycles; stalls keep clk low.
    int hi_run5 = 0, lo_run5 = 0;
    logic prev5 = 1'b0, saw_fetch5 = 1'b0;
    always @(negedge clk) begin
        if (cclk5) begin
            if (!prev5) begin
                if (!saw_fetch5) check("u5_lo_len", lo_run5, 3);
                lo_run5 = 0;
                saw_fetch5 = 1'b0;
            end
            hi_run5++;
        end else begin
            if (prev5) begin
                check("u5_hi_len", hi_run5, 3);
                hi_run5 = 0;
            end
            lo_run5++;
            if (w5.word_ready) saw_fetch5 = 1'b1;
        end
        if (w5.word_ready && !w5.word_valid) begin
            check("u5_stall_clk_low", cclk5, 0);
            check("u5_stall_en_high", cen5, 1);
        end
        prev5 = cclk5;
    end

    // ---------------- driver tasks ----------------
    task automatic feed1(input logic [7:0] w);
        w1.word_data = w;
        w1.word_valid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            if (w1.word_ready) begin
                @(negedge clk);
                w1.word_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        check("u1_feed_timeout", 1, 0);
        w1.word_valid = 1'b0;
    endtask

    task automatic feed4(input logic [15:0] w);
        w4.word_data = w;
        w4.word_valid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            if (w4.word_ready) begin
                @(negedge clk);
                w4.word_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        check("u4_feed_timeout", 1, 0);
        w4.word_valid = 1'b0;
    endtask

    task automatic feed5(input logic [31:0] w, input int stall);
        repeat (stall) @(negedge clk);
        w5.word_data = w;
        w5.word_valid = 1'b1;
        for (int t = 0; t < 1000; t++) begin
            if (w5.word_ready) begin
                @(negedge clk);
                w5.word_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        check("u5_feed_timeout", 1, 0);
        w5.word_valid = 1'b0;
    endtask

    task automatic run1(input logic [7:0] w, input logic v, input logic [7:0] mask,
                        input logic exp_err, input logic [15:0] exp_cnt);
        int t, mism, n_exp;
        rises1.delete();
        nrise1 = 0;
        flip1 = mask;
        ndone1 = 0;
        start1 = 1'b1;
        verify1 = v;
        @(negedge clk);
        start1 = 1'b0;
        verify1 = 1'b0;
        check("u1_busy_after_start", busy1, 1);
        check("u1_error_cleared", err1, 0);
        check("u1_errcnt_cleared", ecnt1, 0);
        feed1(w);
        if (v) feed1(w);
        t = 0;
        while (!done1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("u1_done_seen", done1, 1);
        check("u1_busy_at_done", busy1, 0);
        check("u1_error", err1, exp_err);
        check("u1_err_count", ecnt1, exp_cnt);
        repeat (3) @(negedge clk);
        check("u1_done_pulses", ndone1, 1);
        check("u1_error_sticky", err1, exp_err);
        check("u1_en_after_done", cen1, 0);
        n_exp = v ? 16 : 8;
        check("u1_rise_count", rises1.size(), n_exp);
        mism = 0;
        for (int i = 0; i < n_exp && i < rises1.size(); i++) if (rises1[i] !== w[i % 8]) mism++;
        check("u1_rise_bits", mism, 0);
    endtask

    task automatic run4(input logic [15:0] w);
        int t, mism;
        rises4.delete();
        ndone4 = 0;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        feed4(w);
        t = 0;
        while (!done4 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("u4_done_seen", done4, 1);
        repeat (2) @(negedge clk);
        check("u4_done_pulses", ndone4, 1);
        check("u4_rise_count", rises4.size(), 4);
        mism = 0;
        for (int k = 0; k < 4 && k < rises4.size(); k++) if (rises4[k] !== w[4*k +: 4]) mism++;
        check("u4_rise_slices", mism, 0);
    endtask

    // Reference: pulse i of each pass carries stream bit i; each corrupted stored bit costs one count.
    task automatic run5(input logic [31:0] a, input logic [31:0] b, input logic v,
                        input logic [63:0] mask, input int stall_max, input int stall_fix);
        logic [63:0] stream;
        int t, mism, exp_cnt;
        stream = {b, a};
        exp_q.delete();
        for (int p = 0; p < (v ? 2 : 1); p++) for (int i = 0; i < 64; i++) exp_q.push_back(stream[i]);
        exp_cnt = 0;
        if (v) for (int i = 0; i < 64; i++) if (mask[i]) exp_cnt++;
        rises5.delete();
        nrise5 = 0;
        flip5 = mask;
        ndone5 = 0;
        start5 = 1'b1;
        verify5 = v;
        @(negedge clk);
        start5 = 1'b0;
        verify5 = 1'b0;
        for (int p = 0; p < (v ? 2 : 1); p++) begin
            feed5(a, (stall_fix >= 0) ? stall_fix : $urandom_range(0, stall_max));
            feed5(b, (stall_fix >= 0) ? stall_fix : $urandom_range(0, stall_max));
        end
        t = 0;
        while (!done5 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("u5_done_seen", done5, 1);
        check("u5_error", err5, (exp_cnt != 0));
        check("u5_err_count", ecnt5, exp_cnt);
        repeat (2) @(negedge clk);
        check("u5_done_pulses", ndone5, 1);
        check("u5_rise_count", rises5.size(), exp_q.size());
        mism = 0;
        for (int i = 0; i < exp_q.size() && i < rises5.size(); i++) if (rises5[i] !== exp_q[i]) mism++;
        check("u5_rise_bits", mism, 0);
    endtask

    typedef struct {
        logic [7:0]  word;
        logic        verify;
        logic [7:0]  mask;
        logic        exp_err;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[7];

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        logic [63:0] mask;
        w1.word_valid = 1'b0; w1.word_data = '0;
        w4.word_valid = 1'b0; w4.word_data = '0;
        w5.word_valid = 1'b0; w5.word_data = '0;

        vecs[0] = '{8'hA5, 1'b0, 8'h00, 1'b0, 16'd0};
        vecs[1] = '{8'hA5, 1'b1, 8'h00, 1'b0, 16'd0};
        vecs[2] = '{8'hA5, 1'b1, 8'h08, 1'b1, 16'd1};
        vecs[3] = '{8'h3C, 1'b1, 8'h81, 1'b1, 16'd2};
        vecs[4] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 16'd8};
        vecs[5] = '{8'h00, 1'b0, 8'h10, 1'b0, 16'd0};
        vecs[6] = '{8'h5A, 1'b1, 8'h00, 1'b0, 16'd0};

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_u1_clk", cclk1, 0);
        check("rst_u1_en", cen1, 0);
        check("rst_u1_ready", w1.word_ready, 0);
        check("rst_u1_busy", busy1, 0);
        check("rst_u1_done", done1, 0);
        check("rst_u1_error", err1, 0);
        check("rst_u1_errcnt", ecnt1, 0);
        check("rst_u1_cin", cin1, 0);
        check("rst_u4_outs", {cclk4, cen4, busy4, done4, err4, w4.word_ready, cin4}, 0);
        check("rst_u5_outs", {cclk5, cen5, busy5, done5, err5, w5.word_ready, cin5}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // word_valid while idle must not be taken and start with start low does nothing.
        w1.word_valid = 1'b1; w1.word_data = 8'hFF;
        repeat (3) @(negedge clk);
        check("idle_ready_low", w1.word_ready, 0);
        check("idle_busy_low", busy1, 0);
        w1.word_valid = 1'b0;

        foreach (vecs[i]) run1(vecs[i].word, vecs[i].verify, vecs[i].mask, vecs[i].exp_err, vecs[i].exp_cnt);

        // Start while busy is ignored: rise count stays at one pass.
        rises1.delete(); nrise1 = 0; ndone1 = 0; flip1 = '0;
        start1 = 1'b1; verify1 = 1'b0;
        @(negedge clk);
        verify1 = 1'b1;
        feed1(8'hC3);
        start1 = 1'b0; verify1 = 1'b0;
        t = 0;
        while (!done1 && t < 200) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        check("busy_start_rises", rises1.size(), 8);
        check("busy_start_done", ndone1, 1);

        // Reset in the middle of a HI phase.
        ndone1 = 0;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        w1.word_data = 8'hA5; w1.word_valid = 1'b1;
        t = 0;
        while (!cclk1 && t < 100) begin @(negedge clk); t++; end
        check("midrst_reached_hi", cclk1, 1);
        w1.word_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_clk", cclk1, 0);
        check("midrst_en", cen1, 0);
        check("midrst_busy", busy1, 0);
        check("midrst_state", st1, ST_IDLE);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_no_done", ndone1, 0);
        run1(8'hA5, 1'b0, 8'h00, 1'b0, 16'd0);

        // Four chains in parallel.
        run4(16'h8421);
        if (rises4.size() == 4) begin
            check("u4_chain0", {rises4[3][0], rises4[2][0], rises4[1][0], rises4[0][0]}, 4'b0001);
            check("u4_chain1", {rises4[3][1], rises4[2][1], rises4[1][1], rises4[0][1]}, 4'b0010);
            check("u4_chain2", {rises4[3][2], rises4[2][2], rises4[1][2], rises4[0][2]}, 4'b0100);
            check("u4_chain3", {rises4[3][3], rises4[2][3], rises4[1][3], rises4[0][3]}, 4'b1000);
        end else begin
            check("u4_chain_rises", rises4.size(), 4);
        end
        run4(16'($urandom));
        run4(16'($urandom));

        // Long chain with 10-cycle stalls between words.
        run5(32'hDEADBEEF, 32'h0123_4567, 1'b0, 64'd0, 0, 10);
        run5(32'hCAFEF00D, 32'h8000_0001, 1'b1, 64'd0, 0, 10);

        // Randomized runs against the stream reference model.
        for (int r = 0; r < 6; r++) begin
            mask = '0;
            repeat ($urandom_range(0, 3)) mask[$urandom_range(0, 63)] = 1'b1;
            run5($urandom, $urandom, 1'($urandom_range(0, 1)), mask, 4, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
